// File: rtl/alu_op_sequencer.sv
// Command FIFO + result register around the 4-bit ALU; a command into an empty queue is captured one edge after acceptance.
// Result slot holds under res_ready low, FIFO absorbs DEPTH more; optional res_zero/res_wide flags via `ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  output logic [3:0]               alu_opcode,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  input  logic [3:0]               alu_x,
  input  logic [3:0]               alu_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [3:0]               res_opcode,
  output logic                     res_zero,
  output logic                     res_wide,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          push;
  logic          capture;

  assign fifo_empty = (level == '0);
  // Ready is a function of occupancy only, never of a same-cycle pop.
  assign cmd_ready  = rst_n && (level < LW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign capture    = !fifo_empty && (!res_valid || res_ready);

  assign head       = fifo_empty ? '0 : mem[rd_ptr];
  assign alu_opcode = head.opcode;
  assign alu_a      = head.a;
  assign alu_b      = head.b;

  // Storage needs no reset: entries are only read while counted in level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (capture) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !capture) begin
        level <= level + LW'(1);
      end else if (!push && capture) begin
        level <= level - LW'(1);
      end
      if (capture) begin
        res_valid  <= 1'b1;
        res_data   <= {alu_y, alu_x};
        res_opcode <= head.opcode;
      end else if (res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q;
  logic wide_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      wide_q <= 1'b0;
    end else if (capture) begin
      zero_q <= ({alu_y, alu_x} == 8'h00);
      wide_q <= (alu_y != 4'h0);
    end
  end

  assign res_zero = zero_q;
  assign res_wide = wide_q;
`else
  assign res_zero = 1'b0;
  assign res_wide = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stand-in, queue-based reference model, directed vectors and random traffic.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_opcode;
  logic       res_zero;
  logic       res_wide;
  logic [$clog2(DEPTH):0] level;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_x(alu_x), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode),
    .res_zero(res_zero), .res_wide(res_wide),
    .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the combinational ALU; x-only operations leave y at zero.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    case (op)
      4'b1010: alu_f = {4'h0, a} + {4'h0, b};
      4'b1011: begin d = a - b; alu_f = {4'h0, d}; end
      4'b1100: alu_f = {4'h0, a} * {4'h0, b};
      4'b1110: alu_f = {4'h0, a} << b;
      4'b1101: alu_f = {4'h0, a >> b};
      4'b0000: alu_f = {4'h0, a & b};
      4'b0001: alu_f = {4'h0, a | b};
      default: alu_f = {4'h0, a ^ b};
    endcase
  endfunction

  assign {alu_y, alu_x} = alu_f(alu_opcode, alu_a, alu_b);

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } tcmd_t;

  // Reference model: pending commands plus the single result slot.
  tcmd_t      mq[$];
  logic       m_vld;
  logic [7:0] m_data;
  logic [3:0] m_op;
  logic       m_zero;
  logic       m_wide;
  logic       last_rdy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string nm, input logic [7:0] d, input logic [3:0] op,
                         input logic z, input logic w);
    check({nm, " valid"}, res_valid, 1);
    check({nm, " data"}, res_data, d);
    check({nm, " opcode"}, res_opcode, op);
`ifdef ALU_SEQ_FLAGS_EN
    check({nm, " zero"}, res_zero, z);
    check({nm, " wide"}, res_wide, w);
`else
    check({nm, " zero"}, res_zero, 0);
    check({nm, " wide"}, res_wide, 0);
`endif
  endtask

  // One clock cycle: drive, compare against the model, take the edge, advance the model.
  task automatic cyc(input logic cv, input logic [3:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic rr);
    logic  exp_rdy;
    logic  push;
    logic  cap;
    tcmd_t c;
    cmd_valid = cv; cmd_opcode = op; cmd_a = a; cmd_b = b; res_ready = rr;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    check("cmd_ready", cmd_ready, exp_rdy);
    check("level", level, mq.size());
    check("res_valid", res_valid, m_vld);
    check("res_data", res_data, m_data);
    check("res_opcode", res_opcode, m_op);
    check("res_zero", res_zero, m_zero);
    check("res_wide", res_wide, m_wide);
    c = (mq.size() > 0) ? mq[0] : '0;
    check("alu_head", {alu_opcode, alu_a, alu_b}, c);
    last_rdy = cmd_ready;
    push = cv && exp_rdy;
    cap  = (mq.size() > 0) && (!m_vld || rr);
    @(posedge clk);
    #1;
    if (cap) begin
      c      = mq.pop_front();
      m_data = alu_f(c.op, c.a, c.b);
      m_op   = c.op;
      m_vld  = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
      m_zero = (m_data == 8'h00);
      m_wide = (m_data[7:4] != 4'h0);
`endif
    end else if (rr) begin
      m_vld = 1'b0;
    end
    if (push) mq.push_back('{op: op, a: a, b: b});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    #1;
    check("rst cmd_ready low", cmd_ready, 0);
    @(posedge clk);
    #1;
    mq.delete();
    m_vld = 0; m_data = 0; m_op = 0; m_zero = 0; m_wide = 0;
    check("rst level", level, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst res_opcode", res_opcode, 0);
    check("rst res_zero", res_zero, 0);
    check("rst res_wide", res_wide, 0);
    check("rst cmd_ready held", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post-rst cmd_ready", cmd_ready, 1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] d;
    logic       z;
    logic       w;
  } vec_t;

  vec_t       vt[6];
  tcmd_t      bp[6];
  logic [7:0] bp_exp[5];
  logic       bp_wide[5];
  int         acc;

  initial begin
    vt[0] = '{op: 4'b1010, a: 4'd9,  b: 4'd8,  d: 8'h11, z: 1'b0, w: 1'b1};
    vt[1] = '{op: 4'b1100, a: 4'd15, b: 4'd15, d: 8'hE1, z: 1'b0, w: 1'b1};
    vt[2] = '{op: 4'b1011, a: 4'd3,  b: 4'd5,  d: 8'h0E, z: 1'b0, w: 1'b0};
    vt[3] = '{op: 4'b1011, a: 4'd7,  b: 4'd7,  d: 8'h00, z: 1'b1, w: 1'b0};
    vt[4] = '{op: 4'b1110, a: 4'd15, b: 4'd2,  d: 8'h3C, z: 1'b0, w: 1'b1};
    vt[5] = '{op: 4'b1101, a: 4'd12, b: 4'd2,  d: 8'h03, z: 1'b0, w: 1'b0};

    bp[0] = '{op: 4'b1010, a: 4'd1, b: 4'd2};
    bp[1] = '{op: 4'b1010, a: 4'd3, b: 4'd4};
    bp[2] = '{op: 4'b1100, a: 4'd2, b: 4'd3};
    bp[3] = '{op: 4'b1011, a: 4'd9, b: 4'd1};
    bp[4] = '{op: 4'b1110, a: 4'd3, b: 4'd3};
    bp[5] = '{op: 4'b1101, a: 4'd8, b: 4'd1};
    bp_exp  = '{8'h03, 8'h07, 8'h06, 8'h08, 8'h18};
    bp_wide = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Single commands: latency and result values
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b1);
      check("latency not yet valid", res_valid, 0);
      cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
      chk_res("vector", vt[i].d, vt[i].op, vt[i].z, vt[i].w);
      cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
      check("vector drained", res_valid, 0);
    end

    // Back-to-back multiply then subtract
    cyc(1'b1, 4'b1100, 4'd15, 4'd15, 1'b1);
    cyc(1'b1, 4'b1011, 4'd3, 4'd5, 1'b1);
    chk_res("b2b mul", 8'hE1, 4'b1100, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk_res("b2b sub", 8'h0E, 4'b1011, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Backpressure: six offered, DEPTH+1 absorbed
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, bp[i].op, bp[i].a, bp[i].b, 1'b0);
      if (last_rdy) acc++;
    end
    check("bp accepted", acc, 5);
    check("bp level full", level, 4);
    check("bp cmd_ready low", cmd_ready, 0);
    chk_res("bp hold0", bp_exp[0], bp[0].op, 1'b0, bp_wide[0]);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk_res("bp hold2", bp_exp[0], bp[0].op, 1'b0, bp_wide[0]);
    for (int i = 0; i < 5; i++) begin
      chk_res("bp drain", bp_exp[i], bp[i].op, 1'b0, bp_wide[i]);
      cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    end
    check("bp empty after drain", res_valid, 0);

    // Reset with 3 queued and 1 held
    for (int i = 0; i < 4; i++) cyc(1'b1, bp[i].op, bp[i].a, bp[i].b, 1'b0);
    check("pre-rst level", level, 3);
    check("pre-rst res_valid", res_valid, 1);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    check("no stale result", res_valid, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
